sha_1_ctrl: RTL and testbench

Message sequencer for the `sha_1` compression core. It accepts a byte-oriented message as a stream of 32-bit big-endian words and applies SHA-1 padding: the 0x80 marker, zero fill, and the 64-bit bit length. It assembles 512-bit blocks, issues them to the core with an incrementing block index, and returns the 160-bit digest of the whole message. It sits between the host/DMA stream and a single `sha_1` instance, and is the only driver of that core's `Data`, `Index` and `Enable`.

---
 rtl/sha_1_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sha_1_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_1_ctrl.sv
// Sequences a byte-oriented big-endian word stream into padded 512-bit SHA-1 blocks for one sha_1 core.
// The block buffer is also core_data; it is only rewritten in IDLE/FILL/PAD, so it holds through SEND/WAIT.
module sha_1_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [511:0] core_data,
  output logic [63:0]  core_index,
  output logic         core_enable,
  input  logic [159:0] core_hash,
  input  logic         core_ready,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT, DONE} state_t;

  state_t            state_q;
  logic [15:0][31:0] buf_q;
  logic [4:0]        wp_q;
  logic [63:0]       blk_q;
  logic [63:0]       len_q;
  logic [63:0]       core_index_q;
  logic              mark_pend_q;
  logic              len_ok_q;
  logic              final_q;
  logic              ended_q;
  logic              core_enable_q;
  logic              digest_valid_q;
  logic              busy_q;
  logic [159:0]      digest_q;

  logic [2:0]  nb_d;
  logic [3:0]  widx_d;
  logic [31:0] tail_word_d;
  logic [31:0] pad_word_d;
  logic        hs_d;

  always_comb begin
    nb_d     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    widx_d   = 4'd15 - wp_q[3:0];
    in_ready = ((state_q == IDLE) || (state_q == FILL)) && !wp_q[4];
    hs_d     = in_valid && in_ready;
    case (nb_d)
      3'd0:    tail_word_d = 32'h8000_0000;
      3'd1:    tail_word_d = {in_data[31:24], 24'h80_0000};
      3'd2:    tail_word_d = {in_data[31:16], 16'h8000};
      3'd3:    tail_word_d = {in_data[31:8], 8'h80};
      default: tail_word_d = in_data;
    endcase
    if (mark_pend_q)                           pad_word_d = 32'h8000_0000;
    else if ((wp_q < 5'd14) || !len_ok_q)      pad_word_d = 32'h0;
    else if (wp_q == 5'd14)                    pad_word_d = len_q[63:32];
    else                                       pad_word_d = len_q[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      wp_q           <= '0;
      blk_q          <= '0;
      len_q          <= '0;
      core_index_q   <= '0;
      mark_pend_q    <= 1'b0;
      len_ok_q       <= 1'b0;
      final_q        <= 1'b0;
      ended_q        <= 1'b0;
      core_enable_q  <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      digest_q       <= '0;
    end else begin
      core_enable_q  <= 1'b0;
      digest_valid_q <= 1'b0;
      case (state_q)
        IDLE, FILL: begin
          if (hs_d) begin
            buf_q[widx_d] <= (in_last && (nb_d != 3'd4)) ? tail_word_d : in_data;
            wp_q          <= wp_q + 5'd1;
            busy_q        <= 1'b1;
            state_q       <= FILL;
            if (in_last) begin
              ended_q <= 1'b1;
              state_q <= PAD;
              if (nb_d == 3'd4) begin
                // Marker goes into the following word, possibly the next block.
                len_q       <= len_q + 64'd32;
                mark_pend_q <= 1'b1;
                len_ok_q    <= (wp_q <= 5'd12);
              end else begin
                len_q    <= len_q + {58'd0, nb_d, 3'd0};
                len_ok_q <= (wp_q <= 5'd13);
              end
            end else begin
              len_q <= len_q + 64'd32;
              if (wp_q == 5'd15) begin
                state_q       <= SEND;
                core_enable_q <= 1'b1;
                core_index_q  <= blk_q;
              end
            end
          end
        end
        PAD: begin
          if (wp_q[4]) begin
            state_q       <= SEND;
            core_enable_q <= 1'b1;
            core_index_q  <= blk_q;
          end else begin
            buf_q[widx_d] <= pad_word_d;
            wp_q          <= wp_q + 5'd1;
            if (mark_pend_q) begin
              mark_pend_q <= 1'b0;
              len_ok_q    <= (wp_q <= 5'd13);
            end else if (len_ok_q && (wp_q == 5'd15)) begin
              final_q <= 1'b1;
            end
            if (wp_q == 5'd15) begin
              state_q       <= SEND;
              core_enable_q <= 1'b1;
              core_index_q  <= blk_q;
            end
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (core_ready) begin
            blk_q <= blk_q + 64'd1;
            wp_q  <= '0;
            if (final_q) begin
              digest_q       <= core_hash;
              digest_valid_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= DONE;
            end else if (ended_q) begin
              // Overflow block: length did not fit after the marker.
              len_ok_q <= 1'b1;
              state_q  <= PAD;
            end else begin
              state_q <= FILL;
            end
          end
        end
        DONE: begin
          blk_q       <= '0;
          len_q       <= '0;
          wp_q        <= '0;
          mark_pend_q <= 1'b0;
          len_ok_q    <= 1'b0;
          final_q     <= 1'b0;
          ended_q     <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_data    = buf_q;
  assign core_index   = core_index_q;
  assign core_enable  = core_enable_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_sha_1_ctrl.sv
// Directed bench for sha_1_ctrl with a behavioural SHA-1 core model behind it.
module tb_sha_1_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic [511:0] core_data;
  logic [63:0]  core_index;
  logic         core_enable;
  logic [159:0] core_hash = '0;
  logic         core_ready = 1'b0;
  logic [159:0] digest;
  logic         digest_valid;
  logic         busy;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  sha_1_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .core_data(core_data), .core_index(core_index), .core_enable(core_enable),
    .core_hash(core_hash), .core_ready(core_ready),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int core_dly = 3;
  int cyc = 0;
  int dv_n = 0;
  int hs_n = 0;
  int hs16_cyc = -1;
  logic prev_rdy = 1'b1;
  logic [159:0] hc = '0;
  logic [31:0]  msg[$];
  logic [511:0] blks[$];
  logic [63:0]  idxs[$];
  logic [31:0]  acc[$];
  int en_cyc[$];
  int rdy_cyc[$];
  int rise_cyc[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [159:0] sha1(input logic [159:0] h, input logic [511:0] b);
    logic [31:0] w[80];
    logic [31:0] a, bb, c, d, e, f, k, tmp;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, bb, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ d;                    k = 32'hca62c1d6; end
      tmp = rotl(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rotl(bb, 30); bb = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [31:0] bword(input int b, input int w);
    logic [511:0] t;
    if (b >= blks.size()) return 32'hdead_beef;
    t = blks[b];
    return t[511-32*w -: 32];
  endfunction

  // Core model: one block in flight, core_ready core_dly cycles after core_enable.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (core_enable) begin
        hc = sha1((core_index == 64'd0) ? IV : hc, core_data);
        repeat (core_dly) @(posedge clk);
        #1 core_ready = 1'b1;
        core_hash = hc;
        @(posedge clk); #1;
        core_ready = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      acc.push_back(in_data);
      hs_n++;
      if (hs_n == 16) hs16_cyc = cyc;
    end
    if (core_enable) begin
      blks.push_back(core_data);
      idxs.push_back(core_index);
      en_cyc.push_back(cyc);
    end
    if (core_ready) rdy_cyc.push_back(cyc);
    if (in_ready && !prev_rdy) rise_cyc.push_back(cyc);
    prev_rdy = in_ready;
    if (digest_valid) dv_n++;
  end

  task automatic clr();
    blks.delete(); idxs.delete(); acc.delete();
    en_cyc.delete(); rdy_cyc.delete(); rise_cyc.delete();
    hs_n = 0; hs16_cyc = -1;
  endtask

  task automatic send_msg(input int nb);
    for (int i = 0; i < msg.size(); i++) begin
      int t;
      in_valid  = 1'b1;
      in_data   = msg[i];
      in_last   = (i == msg.size() - 1);
      in_nbytes = nb[2:0];
      t = 0;
      while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
      if (t >= 1000) check("in_ready_timeout", 160'(t), 160'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int target);
    int t = 0;
    while (dv_n < target && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1 check(tag, 160'(dv_n), 160'(target));
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_dv;
    int errs;
    int rise;
    exp_dv = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_in_ready", 160'(in_ready), 160'd1);
    check("rst_core_enable", 160'(core_enable), 160'd0);
    check("rst_core_data_hi", core_data[511:352], 160'd0);
    check("rst_core_index", 160'(core_index), 160'd0);
    check("rst_digest", digest, 160'd0);
    check("rst_digest_valid", 160'(digest_valid), 160'd0);
    check("rst_busy", 160'(busy), 160'd0);

    // "abc"
    clr(); msg = {32'h6162_6300};
    send_msg(3);
    check("abc_busy", 160'(busy), 160'd1);
    exp_dv++; wait_dv("abc_dv", exp_dv);
    check("abc_blocks", 160'(blks.size()), 160'd1);
    check("abc_index", 160'(idxs.size() > 0 ? idxs[0] : 64'hffff), 160'd0);
    check("abc_w0", 160'(bword(0, 0)), 160'h6162_6380);
    check("abc_w15", 160'(bword(0, 15)), 160'h18);
    check("abc_digest", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
    check("abc_busy_done", 160'(busy), 160'd0);

    // empty message
    clr(); msg = {32'h0};
    send_msg(0);
    exp_dv++; wait_dv("empty_dv", exp_dv);
    check("empty_w0", 160'(bword(0, 0)), 160'h8000_0000);
    check("empty_w15", 160'(bword(0, 15)), 160'd0);
    check("empty_digest", digest, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);

    // 56-byte message: length spills into a second block
    clr(); msg.delete();
    for (int k = 0; k < 14; k++) begin
      logic [7:0] c0;
      c0 = 8'h61 + 8'(k);
      msg.push_back({c0, c0 + 8'd1, c0 + 8'd2, c0 + 8'd3});
    end
    send_msg(4);
    exp_dv++; wait_dv("m56_dv", exp_dv);
    check("m56_blocks", 160'(blks.size()), 160'd2);
    check("m56_index1", 160'(idxs.size() > 1 ? idxs[1] : 64'hffff), 160'd1);
    check("m56_b0_w14", 160'(bword(0, 14)), 160'h8000_0000);
    check("m56_b0_w15", 160'(bword(0, 15)), 160'd0);
    check("m56_b1_w0", 160'(bword(1, 0)), 160'd0);
    check("m56_b1_w13", 160'(bword(1, 13)), 160'd0);
    check("m56_b1_w15", 160'(bword(1, 15)), 160'h1c0);
    check("m56_digest", digest, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);

    // exactly 64 bytes: unpadded block then a pure padding block
    clr(); msg.delete();
    for (int k = 0; k < 16; k++) msg.push_back({4{8'h40 + 8'(k)}});
    send_msg(4);
    exp_dv++; wait_dv("m64_dv", exp_dv);
    check("m64_blocks", 160'(blks.size()), 160'd2);
    check("m64_b0_w0", 160'(bword(0, 0)), 160'h4040_4040);
    check("m64_b0_w15", 160'(bword(0, 15)), 160'h4f4f_4f4f);
    check("m64_index1", 160'(idxs.size() > 1 ? idxs[1] : 64'hffff), 160'd1);
    check("m64_b1_w0", 160'(bword(1, 0)), 160'h8000_0000);
    check("m64_b1_w15", 160'(bword(1, 15)), 160'h200);

    // backpressure with a slow core
    core_dly = 80;
    clr(); msg.delete();
    for (int k = 0; k < 20; k++) msg.push_back({8'ha5, 8'(k), 16'h5a5a});
    send_msg(4);
    exp_dv++; wait_dv("bp_dv", exp_dv);
    check("bp_enable_lat", 160'(en_cyc.size() > 0 ? en_cyc[0] : -1), 160'(hs16_cyc + 1));
    rise = -1;
    foreach (rise_cyc[i]) if (rise < 0 && rise_cyc[i] > hs16_cyc) rise = rise_cyc[i];
    check("bp_ready_return", 160'(rise), 160'(rdy_cyc.size() > 0 ? rdy_cyc[0] + 1 : -2));
    check("bp_word_count", 160'(acc.size()), 160'd20);
    errs = 0;
    for (int k = 0; k < 20; k++) if (k >= acc.size() || acc[k] !== msg[k]) errs++;
    check("bp_word_order", 160'(errs), 160'd0);

    // reset while the second block of a message is in WAIT
    core_dly = 40;
    clr(); msg.delete();
    for (int k = 0; k < 14; k++) begin
      logic [7:0] c0;
      c0 = 8'h61 + 8'(k);
      msg.push_back({c0, c0 + 8'd1, c0 + 8'd2, c0 + 8'd3});
    end
    send_msg(4);
    for (int t = 0; t < 500 && blks.size() < 2; t++) begin @(posedge clk); #1; end
    check("mr_second_block", 160'(blks.size()), 160'd2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check("mr_in_ready", 160'(in_ready), 160'd1);
    check("mr_core_index", 160'(core_index), 160'd0);
    check("mr_core_data_lo", core_data[159:0], 160'd0);
    check("mr_digest", digest, 160'd0);
    check("mr_busy", 160'(busy), 160'd0);
    repeat (100) @(posedge clk);
    #1 check("mr_stray_ready", 160'(dv_n), 160'(exp_dv));
    core_dly = 3;
    clr(); msg = {32'h6162_6300};
    send_msg(3);
    exp_dv++; wait_dv("mr_abc_dv", exp_dv);
    check("mr_abc_digest", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
